alus_iter: RTL and testbench
============================

# alus_iter

Parametrised iterative shift/rotate unit for the Gumnut datapath. It is the multi-cycle successor to the combinational 8-bit shifter.
- Widens the datapath to WIDTH bits.
- Adds arithmetic shift right and rotate-through-carry.
- Performs one bit position per clock behind a start/ready/done handshake, so no wide barrel network is needed.

The core sequencer issues shift instructions here and stalls until `done`.

## Interface
- WIDTH, 8: operand/result width, ≥ 2.
- CNT_W, $clog2(WIDTH)+1: width of the shift-count port. It can encode WIDTH.

- clk_i  input  1  single clock, all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- start_i  input  1  request; sampled only when `ready`=1.
- op_i  input  3  operation select.
- rs_i  input  WIDTH  source operand.
- count_i  input  CNT_W  shift amount; values > WIDTH saturate to WIDTH.
- cin_i  input  1  carry-in, used only by RCL/RCR.
- ready  output  1  unit idle; high only in IDLE.
- done  output  1  one-cycle pulse; `res`/`cout` valid.
- res  output  WIDTH  result; held stable from `done` until the next accepted start.
- cout  output  1  carry-out; held with `res`.

## Operation
- Op encoding:
  - 000 SHL: shift left, 0 filled in.
  - 001 SHR: logical shift right.
  - 010 ROL: rotate left.
  - 011 ROR: rotate right.
  - 100 SAR: arithmetic right shift, MSB replicated.
  - 101 RCL: rotate left through carry, WIDTH+1-bit ring {c,r}.
  - 110 RCR: rotate right through carry.
  - 111 reserved: pass-through. `res`=rs_i and `cout`=0 regardless of count.
- Start accepted when `start_i`=1 in IDLE. That edge latches rs_i into the working register and op_i internally. It also latches min(count_i, WIDTH) into the down-counter and cin_i into the carry register.
- FSM states:
  - IDLE: on accept, go to SHIFT if the saturated count > 0 and op ≠ 111; otherwise go to DONE.
  - SHIFT: perform one single-bit step per cycle and decrement the counter. When the counter transitions 1→0, go to DONE.
  - DONE: `done`=1 for exactly this cycle, then return to IDLE unconditionally.
- Single-bit step definitions:
  - SHL: c←r[W-1], r←{r[W-2:0],0}.
  - SHR: c←r[0], r←{0,r[W-1:1]}.
  - SAR: c←r[0], r←{r[W-1],r[W-1:1]}.
  - ROL: r←{r[W-2:0],r[W-1]}, c←new r[0].
  - ROR: r←{r[0],r[W-1:1]}, c←new r[W-1].
  - RCL: {c,r}←{r[W-1], r[W-2:0], c}.
  - RCR: {r,c}←{c, r[W-1:0]}.
- Count 0: `res`=rs_i. `cout`=cin_i for RCL/RCR, 0 for every other op.
- The carry register is cleared to 0 at accept for non-RC ops.
- `res` and `cout` are driven from the working and carry registers. They may change during SHIFT and are meaningful only from `done` onward.
- `start_i` while `ready`=0 is ignored and not queued. op_i, rs_i, count_i and cin_i are don't-care outside the accept edge.

## Timing
- Reset (rst_ni=0, asynchronous) forces state=IDLE, `res`=0, `cout`=0, `done`=0, counter=0. `ready`=1 throughout reset.
- Reset mid-SHIFT or in DONE aborts the operation immediately. No `done` pulse follows.
- Latency: `done` is high in the cycle following the (N+1)th rising edge counted from, and including, the accept edge. N is the saturated count, or 0 for op 111.
- Throughput: one operation per N+2 cycles. The next start is accepted in the IDLE cycle after `done`; `ready` is low during DONE.
- `ready` and `done` are decoded from state registers only, so they are glitch-free with no input-to-output combinational path.

## Test plan
- WIDTH=8, SHL rs=0x96 cnt=3: `res`=0xB0, `cout`=0, `done` 4 edges after accept. Same operand with SAR cnt=2: `res`=0xE5, `cout`=1.
- ROR rs=0x81 cnt=1: `res`=0xC0, `cout`=1. ROL rs=0x81 cnt=8: `res`=0x81, `cout`=1, 9 edges latency.
- RCL rs=0x80 cin=0 cnt=1: `res`=0x00, `cout`=1. RCL rs=0x80 cin=1 cnt=9 (saturates to 8): `res`=0xC0, `cout`=0, `done` 9 edges after accept.
- SHL rs=0x5A cnt=0: `res`=0x5A, `cout`=0, `done` 1 edge after accept. RCR cnt=0 cin=1: `cout`=1. Op 111 rs=0x3C cnt=5: `res`=0x3C, `cout`=0, 1 edge.
- Start pulses held high during SHIFT and DONE: no extra operations. Back-to-back starts: the second is accepted on the IDLE cycle after `done`, with exactly one `done` per accepted start.
- rst_ni low for one cycle mid-SHIFT (SHR cnt=6):
  - outputs immediately `res`=0, `cout`=0, `ready`=1;
  - no `done` afterwards;
  - the next operation completes correctly.

Source files
------------

// File: rtl/alus_iter_if.sv
// ---------------------------------------------------------------------------
// alus_iter_if
// Request/response bundle between the core sequencer and the iterative
// shift/rotate unit.
//   start_i  : request, only looked at while ready is high
//   op_i     : operation select (3 bits)
//   rs_i     : source operand (WIDTH bits)
//   count_i  : shift amount (CNT_W bits), saturates to WIDTH inside the unit
//   cin_i    : carry-in for the rotate-through-carry operations
//   ready    : unit idle and able to accept a request
//   done     : one-cycle pulse, res/cout valid
//   res      : result (WIDTH bits), held until the next accepted request
//   cout     : carry-out, held with res
// master = sequencer side, slave = shift unit side.
// ---------------------------------------------------------------------------
interface alus_iter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] rs_i;
    logic [CNT_W-1:0] count_i;
    logic             cin_i;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] res;
    logic             cout;

    modport master (
        output start_i, op_i, rs_i, count_i, cin_i,
        input  ready, done, res, cout
    );

    modport slave (
        input  start_i, op_i, rs_i, count_i, cin_i,
        output ready, done, res, cout
    );
endinterface

// File: rtl/alus_iter.sv
// ---------------------------------------------------------------------------
// alus_iter
// Iterative WIDTH-bit shift/rotate unit: one bit position per clock behind
// a start/ready/done handshake.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : alus_iter_if slave modport (start/op/rs/count/cin in,
//            ready/done/res/cout out)
// Operations: 000 SHL, 001 SHR, 010 ROL, 011 ROR, 100 SAR, 101 RCL,
// 110 RCR, 111 pass-through (res = rs, cout = 0).
// ---------------------------------------------------------------------------
module alus_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    alus_iter_if.slave   bus
);

    typedef enum logic [2:0] {
        OP_SHL  = 3'b000,
        OP_SHR  = 3'b001,
        OP_ROL  = 3'b010,
        OP_ROR  = 3'b011,
        OP_SAR  = 3'b100,
        OP_RCL  = 3'b101,
        OP_RCR  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // One single-bit step of the selected operation. Returned as {c, r}.
    function automatic logic [WIDTH:0] step_f(
        input op_e              op,
        input logic [WIDTH-1:0] r,
        input logic             c
    );
        logic [WIDTH:0] cr;
        cr = {c, r};
        case (op)
            OP_SHL:  cr = {r[WIDTH-1], r[WIDTH-2:0], 1'b0};
            OP_SHR:  cr = {r[0], 1'b0, r[WIDTH-1:1]};
            OP_SAR:  cr = {r[0], r[WIDTH-1], r[WIDTH-1:1]};
            // Carry mirrors the bit that wrapped around.
            OP_ROL:  cr = {r[WIDTH-1], r[WIDTH-2:0], r[WIDTH-1]};
            OP_ROR:  cr = {r[0], r[0], r[WIDTH-1:1]};
            // Carry is part of a WIDTH+1-bit ring.
            OP_RCL:  cr = {r[WIDTH-1], r[WIDTH-2:0], c};
            OP_RCR:  cr = {r[0], c, r[WIDTH-1:1]};
            default: cr = {c, r};
        endcase
        return cr;
    endfunction

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CNT_W-1:0] sat_cnt_s;
    logic             rc_op_s;
    op_e              op_in_s;

    // Request-side decode: saturated count and carry-using op detection.
    always_comb begin
        op_in_s   = op_e'(bus.op_i);
        sat_cnt_s = bus.count_i;
        if (bus.count_i > CNT_W'(WIDTH)) begin
            sat_cnt_s = CNT_W'(WIDTH);
        end else begin
            sat_cnt_s = bus.count_i;
        end
        rc_op_s = (op_in_s == OP_RCL) || (op_in_s == OP_RCR);
    end

    // Next-state logic for sequencer, working register, carry and counter.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    op_d  = op_in_s;
                    r_d   = bus.rs_i;
                    cnt_d = sat_cnt_s;
                    c_d   = rc_op_s ? bus.cin_i : 1'b0;
                    if ((sat_cnt_s != '0) && (op_in_s != OP_PASS)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                {c_d, r_d} = step_f(op_q, r_q, c_q);
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            op_q    <= OP_SHL;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake flags decode straight from the state register only.
    assign bus.ready = (state_q == ST_IDLE);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.res   = r_q;
    assign bus.cout  = c_q;

endmodule

// File: tb/tb_alus_iter.sv
module tb_alus_iter;
    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic clk;
    logic rst_ni;

    alus_iter_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    alus_iter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        int           acc;
        int           n;
        string        tag;
    } exp_t;

    exp_t sb_q[$];
    int tests = 0;
    int fails = 0;
    int accepted = 0;
    int dones = 0;

    // Reference model: whole-operation arithmetic on integers / rings.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] rs,
                                  input int cnt, input logic cin,
                                  output logic [W-1:0] r, output logic c, output int n);
        int k;
        logic [W:0] v;
        k = (cnt > W) ? W : cnt;
        n = (op == 3'd7) ? 0 : k;
        r = rs;
        c = 1'b0;
        v = {cin, rs};
        case (op)
            3'd0: begin r = rs << k; c = (k > 0) ? rs[W-k] : 1'b0; end
            3'd1: begin r = rs >> k; c = (k > 0) ? rs[k-1] : 1'b0; end
            3'd4: begin r = $signed(rs) >>> k; c = (k > 0) ? rs[k-1] : 1'b0; end
            3'd2: begin r = (rs << k) | (rs >> (W - k)); c = (k > 0) ? r[0] : 1'b0; end
            3'd3: begin r = (rs >> k) | (rs << (W - k)); c = (k > 0) ? r[W-1] : 1'b0; end
            3'd5: begin v = (v << k) | (v >> (W + 1 - k)); {c, r} = v; end
            3'd6: begin v = (v >> k) | (v << (W + 1 - k)); {c, r} = v; end
            default: begin r = rs; c = 1'b0; end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop expected result on every done pulse.
    always @(negedge clk) begin
        if (rst_ni && bus.done === 1'b1) begin
            dones++;
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.tag, "_res"},     32'(bus.res),   32'(e.res));
                chk({e.tag, "_cout"},    32'(bus.cout),  32'(e.cout));
                chk({e.tag, "_latency"}, 32'(cyc - e.acc), 32'(e.n));
                chk({e.tag, "_ready_in_done"}, 32'(bus.ready), 32'd0);
            end
        end
    end

    task automatic issue(input string tag, input logic [2:0] op, input logic [W-1:0] rs,
                         input logic [CW-1:0] cnt, input logic cin, input bit hold);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (bus.ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s_ready_timeout: got ready=%b expected 1", tag, bus.ready);
            return;
        end
        bus.op_i    = op;
        bus.rs_i    = rs;
        bus.count_i = cnt;
        bus.cin_i   = cin;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        model(op, rs, int'(cnt), cin, e.res, e.cout, e.n);
        e.acc = cyc;
        e.tag = tag;
        sb_q.push_back(e);
        accepted++;
        // Scramble inputs: they must not matter after the accept edge.
        bus.op_i    = 3'($urandom);
        bus.rs_i    = W'($urandom);
        bus.count_i = CW'($urandom);
        bus.cin_i   = 1'($urandom);
        if (hold) begin
            guard = 0;
            @(negedge clk);
            while (bus.done !== 1'b1 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (bus.done !== 1'b1) begin
                tests++;
                fails++;
                $display("FAIL %s_done_timeout: got done=%b expected 1", tag, bus.done);
            end
        end
        bus.start_i = 1'b0;
    endtask

    initial begin
        int guard;
        bus.start_i = 1'b0;
        bus.op_i    = 3'd0;
        bus.rs_i    = '0;
        bus.count_i = '0;
        bus.cin_i   = 1'b0;
        rst_ni      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done",  32'(bus.done),  32'd0);
        chk("rst_res",   32'(bus.res),   32'd0);
        chk("rst_cout",  32'(bus.cout),  32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Directed cases.
        issue("shl_96_3",  3'd0, 8'h96, 4'd3, 1'b0, 1'b0);
        issue("sar_96_2",  3'd4, 8'h96, 4'd2, 1'b0, 1'b0);
        issue("ror_81_1",  3'd3, 8'h81, 4'd1, 1'b0, 1'b0);
        issue("rol_81_8",  3'd2, 8'h81, 4'd8, 1'b0, 1'b0);
        issue("rcl_80_1",  3'd5, 8'h80, 4'd1, 1'b0, 1'b0);
        issue("rcl_80_9",  3'd5, 8'h80, 4'd9, 1'b1, 1'b0);
        issue("shl_5a_0",  3'd0, 8'h5A, 4'd0, 1'b1, 1'b0);
        issue("rcr_0_c1",  3'd6, 8'hA5, 4'd0, 1'b1, 1'b0);
        issue("pass_3c_5", 3'd7, 8'h3C, 4'd5, 1'b1, 1'b0);
        issue("rcr_max",   3'd6, 8'h01, 4'd15, 1'b0, 1'b0);
        // Start held high through SHIFT and DONE must not start extra ops.
        issue("hold_shr",  3'd1, 8'hF0, 4'd5, 1'b0, 1'b1);
        issue("hold_pass", 3'd7, 8'h11, 4'd2, 1'b0, 1'b1);

        // Reset mid-SHIFT aborts with no done.
        issue("rst_shr",   3'd1, 8'hC3, 4'd6, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b0;
        sb_q.delete();
        accepted--;
        #1;
        chk("abort_res",   32'(bus.res),   32'd0);
        chk("abort_cout",  32'(bus.cout),  32'd0);
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_done",  32'(bus.done),  32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk);
        issue("post_rst",  3'd1, 8'hC3, 4'd6, 1'b0, 1'b0);

        // Randomised operations.
        for (int i = 0; i < 150; i++) begin
            issue("rnd", 3'($urandom), W'($urandom), CW'($urandom),
                  1'($urandom), ($urandom_range(0, 7) == 0));
        end

        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
        chk("done_count",  32'(dones), 32'(accepted));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
